// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit.
//   md_state_e    : FSM state encoding (IDLE=0, MULT=1, DIV=2, DONE=3)
//   MD_ITERATIONS : number of Booth / restoring-divide iterations
//   MD_WIDTH      : operand and result width
package mips_pkg;

  localparam int MD_WIDTH      = 32;
  localparam int MD_ITERATIONS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/abs_neg32.sv
// Conditional two's-complement negation. Driving neg_i with the operand's
// sign bit yields its magnitude; driving it with a result sign restores sign.
// Ports:
//   x_i   in  32  value
//   neg_i in  1   1 = output -x_i, 0 = output x_i
//   y_o   out 32  result
module abs_neg32
  import mips_pkg::*;
(
  input  logic [MD_WIDTH-1:0] x_i,
  input  logic                neg_i,
  output logic [MD_WIDTH-1:0] y_o
);

  assign y_o = neg_i ? (~x_i + {{(MD_WIDTH-1){1'b0}}, 1'b1}) : x_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply / divide unit.
// Multiply: radix-2 Booth, 32x32 -> 64, one iteration per clock.
// Divide  : restoring division on magnitudes, one quotient bit per clock,
//           quotient truncated toward zero, remainder carries sign of A.
// Optional feature (macro MULT_DIV_DIVZERO_EN): divide by zero finishes one
// cycle after acceptance with Done and DivZero set and HI/LO untouched.
// Without the macro DivZero is tied low and a zero divisor runs the full
// sequence.
// Ports:
//   clock    in  1   rising-edge clock
//   RESET_in in  1   asynchronous active-high reset
//   MultOp   in  1   start signed multiply (sampled in IDLE)
//   DivOp    in  1   start signed divide (sampled in IDLE, multiply wins)
//   A        in  32  multiplicand / dividend
//   B        in  32  multiplier / divisor
//   HI       out 32  product[63:32] / remainder
//   LO       out 32  product[31:0]  / quotient
//   Busy     out 1   high in MULT and DIV
//   Done     out 1   one-cycle completion pulse
//   DivZero  out 1   one-cycle divide-by-zero flag
//
// state | meaning
// IDLE  | waiting for MultOp / DivOp
// MULT  | Booth iterations, then result load
// DIV   | restoring-divide iterations, then sign fix and result load
// DONE  | one-cycle completion, always returns to IDLE
module mult_div_unit
  import mips_pkg::*;
(
  input  logic                clock,
  input  logic                RESET_in,
  input  logic                MultOp,
  input  logic                DivOp,
  input  logic [MD_WIDTH-1:0] A,
  input  logic [MD_WIDTH-1:0] B,
  output logic [MD_WIDTH-1:0] HI,
  output logic [MD_WIDTH-1:0] LO,
  output logic                Busy,
  output logic                Done,
  output logic                DivZero
);

  localparam logic [4:0] LAST_ITER = 5'(MD_ITERATIONS - 1);

  md_state_e           state_q;
  logic [4:0]          cnt_q;
  logic                iter_done_q;
  logic [MD_WIDTH-1:0] m_q;
  logic [MD_WIDTH:0]   hi_acc_q;
  logic [MD_WIDTH-1:0] lo_acc_q;
  logic                qm1_q;
  logic                neg_quo_q;
  logic                neg_rem_q;
  logic [MD_WIDTH-1:0] hi_q;
  logic [MD_WIDTH-1:0] lo_q;
  logic                busy_q;
  logic                done_q;

  logic [MD_WIDTH-1:0] a_mag;
  logic [MD_WIDTH-1:0] b_mag;
  logic [MD_WIDTH-1:0] quo_fix;
  logic [MD_WIDTH-1:0] rem_fix;

  abs_neg32 u_abs_a (.x_i(A), .neg_i(A[MD_WIDTH-1]), .y_o(a_mag));
  abs_neg32 u_abs_b (.x_i(B), .neg_i(B[MD_WIDTH-1]), .y_o(b_mag));
  abs_neg32 u_fix_q (.x_i(lo_acc_q), .neg_i(neg_quo_q), .y_o(quo_fix));
  abs_neg32 u_fix_r (.x_i(hi_acc_q[MD_WIDTH-1:0]), .neg_i(neg_rem_q), .y_o(rem_fix));

  // Booth step. The upper accumulator is one bit wider than the operand so
  // that subtracting a multiplicand of -2^31 cannot overflow.
  logic [MD_WIDTH:0] m_ext;
  logic [MD_WIDTH:0] booth_sum_d;

  assign m_ext = {m_q[MD_WIDTH-1], m_q};

  always_comb begin
    booth_sum_d = hi_acc_q;
    case ({lo_acc_q[0], qm1_q})
      2'b01:   booth_sum_d = hi_acc_q + m_ext;
      2'b10:   booth_sum_d = hi_acc_q - m_ext;
      default: booth_sum_d = hi_acc_q;
    endcase
  end

  // Restoring-divide step: shift the next dividend bit into the partial
  // remainder and keep the trial difference when it does not borrow.
  logic [MD_WIDTH:0] rem_sh_d;
  logic [MD_WIDTH:0] div_trial_d;
  logic              div_ok_d;

  assign rem_sh_d    = {hi_acc_q[MD_WIDTH-1:0], lo_acc_q[MD_WIDTH-1]};
  assign div_trial_d = rem_sh_d - {1'b0, m_q};
  assign div_ok_d    = ~div_trial_d[MD_WIDTH];

`ifdef MULT_DIV_DIVZERO_EN
  logic divzero_q;
  assign DivZero = divzero_q;
`else
  assign DivZero = 1'b0;
`endif

  always_ff @(posedge clock or posedge RESET_in) begin
    if (RESET_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      iter_done_q <= 1'b0;
      m_q         <= '0;
      hi_acc_q    <= '0;
      lo_acc_q    <= '0;
      qm1_q       <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MULT_DIV_DIVZERO_EN
      divzero_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULT_DIV_DIVZERO_EN
      divzero_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (MultOp) begin
            m_q         <= A;
            hi_acc_q    <= '0;
            lo_acc_q    <= B;
            qm1_q       <= 1'b0;
            cnt_q       <= '0;
            iter_done_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_MULT;
          end else if (DivOp) begin
            m_q         <= b_mag;
            hi_acc_q    <= '0;
            lo_acc_q    <= a_mag;
            neg_quo_q   <= A[MD_WIDTH-1] ^ B[MD_WIDTH-1];
            neg_rem_q   <= A[MD_WIDTH-1];
            cnt_q       <= '0;
            iter_done_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_DIV;
          end
        end

        ST_MULT: begin
          if (iter_done_q) begin
            hi_q    <= hi_acc_q[MD_WIDTH-1:0];
            lo_q    <= lo_acc_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            hi_acc_q    <= {booth_sum_d[MD_WIDTH], booth_sum_d[MD_WIDTH:1]};
            lo_acc_q    <= {booth_sum_d[0], lo_acc_q[MD_WIDTH-1:1]};
            qm1_q       <= lo_acc_q[0];
            cnt_q       <= cnt_q + 5'd1;
            iter_done_q <= (cnt_q == LAST_ITER);
          end
        end

        ST_DIV: begin
`ifdef MULT_DIV_DIVZERO_EN
          // Latched divisor magnitude is zero only when B was zero.
          if (m_q == '0) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            divzero_q <= 1'b1;
            state_q   <= ST_DONE;
          end else
`endif
          if (iter_done_q) begin
            hi_q    <= rem_fix;
            lo_q    <= quo_fix;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            hi_acc_q    <= div_ok_d ? div_trial_d : rem_sh_d;
            lo_acc_q    <= {lo_acc_q[MD_WIDTH-2:0], div_ok_d};
            cnt_q       <= cnt_q + 5'd1;
            iter_done_q <= (cnt_q == LAST_ITER);
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clock;
  logic        RESET_in;
  logic        MultOp;
  logic        DivOp;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  mult_div_unit dut (
    .clock   (clock),
    .RESET_in(RESET_in),
    .MultOp  (MultOp),
    .DivOp   (DivOp),
    .A       (A),
    .B       (B),
    .HI      (HI),
    .LO      (LO),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dz;
    bit          chk;
  } exp_t;

  exp_t        scb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain signed 64-bit arithmetic. SystemVerilog division
  // truncates toward zero and % takes the dividend's sign.
  function automatic exp_t model(input bit mop, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sbv;
    longint p;
    longint q;
    longint r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.dz  = 1'b0;
    e.chk = 1'b1;
    if (mop) begin
      p    = sa * sbv;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
`ifdef MULT_DIV_DIVZERO_EN
      e.dz = 1'b1;
      e.hi = mdl_hi;
      e.lo = mdl_lo;
`else
      e.chk = 1'b0;
      e.hi  = '0;
      e.lo  = '0;
`endif
    end else begin
      q    = sa / sbv;
      r    = sa % sbv;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  // Monitor: compares whenever the DUT presents Done.
  always @(negedge clock) begin
    exp_t e;
    if (!RESET_in) begin
      if (Done === 1'b1) begin
        if (scb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = scb.pop_front();
          if (e.chk) begin
            check("HI", {32'd0, HI}, {32'd0, e.hi});
            check("LO", {32'd0, LO}, {32'd0, e.lo});
          end
          check("DivZero", {63'd0, DivZero}, {63'd0, e.dz});
        end
      end else if (DivZero !== 1'b0) begin
        check("divzero_without_done", {63'd0, DivZero}, 64'd0);
      end
    end
  end

  // Issue one operation starting at a negedge with the FSM in IDLE; returns
  // at a negedge with the FSM back in IDLE. pulse_lat > 0 re-asserts DivOp
  // (and MultOp if pulse_m) for one cycle while the operation is running.
  task automatic run_op(input bit mop, input bit dop, input logic [31:0] a, input logic [31:0] b,
                        input bit use_exp, input logic [31:0] ehi, input logic [31:0] elo,
                        input int pulse_lat, input bit pulse_m);
    exp_t e;
    int   lat;
    int   exp_lat;
    bit   busy_ok;
    exp_lat = 34;
`ifdef MULT_DIV_DIVZERO_EN
    if (!mop && dop && b == 32'd0) exp_lat = 2;
`endif
    if (use_exp) begin
      e.hi = ehi; e.lo = elo; e.dz = 1'b0; e.chk = 1'b1;
    end else begin
      e = model(mop, a, b);
    end
    scb.push_back(e);
    if (e.chk) begin
      mdl_hi = e.hi;
      mdl_lo = e.lo;
    end
    MultOp = mop; DivOp = dop; A = a; B = b;
    @(negedge clock);
    MultOp = 1'b0; DivOp = 1'b0; A = $urandom; B = $urandom;
    lat = 1;
    busy_ok = 1'b1;
    while (Done !== 1'b1 && lat < 60) begin
      if (Busy !== 1'b1) busy_ok = 1'b0;
      if (lat == pulse_lat) begin
        DivOp = 1'b1;
        MultOp = pulse_m;
      end
      @(negedge clock);
      MultOp = 1'b0; DivOp = 1'b0;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("busy_while_running", {63'd0, busy_ok}, 64'd1);
    check("busy_at_done", {63'd0, Busy}, 64'd0);
    @(negedge clock);
    check("done_one_cycle", {63'd0, Done}, 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners[0] = 32'h0000_0001;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF;
    corners[4] = 32'h0000_0000;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    RESET_in = 1'b1;
    MultOp = 1'b1; DivOp = 1'b0; A = 32'd5; B = 32'd9;
    #2;
    check("rst_HI", {32'd0, HI}, 64'd0);
    check("rst_LO", {32'd0, LO}, 64'd0);
    check("rst_Busy", {63'd0, Busy}, 64'd0);
    check("rst_Done", {63'd0, Done}, 64'd0);
    check("rst_DivZero", {63'd0, DivZero}, 64'd0);
    @(negedge clock);
    MultOp = 1'b0;
    @(negedge clock);
    RESET_in = 1'b0;

    // First operation issued right at reset release.
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 1'b0);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000, 0, 1'b0);
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0);
    run_op(1'b1, 1'b1, 32'd6, 32'd3, 1'b1, 32'd0, 32'd18, 5, 1'b0);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 0, 1'b0);
    run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 1'b1, 32'd2, 32'hFFFF_FFF2, 0, 1'b0);

    // Reset at E10 of a divide: outputs clear immediately, no Done follows.
    DivOp = 1'b1; A = 32'd1000; B = 32'd7;
    @(negedge clock);
    DivOp = 1'b0;
    repeat (9) @(negedge clock);
    check("busy_before_abort", {63'd0, Busy}, 64'd1);
    @(posedge clock);
    #1 RESET_in = 1'b1;
    #1;
    check("abort_HI", {32'd0, HI}, 64'd0);
    check("abort_LO", {32'd0, LO}, 64'd0);
    check("abort_Busy", {63'd0, Busy}, 64'd0);
    check("abort_Done", {63'd0, Done}, 64'd0);
    mdl_hi = '0; mdl_lo = '0;
    @(negedge clock);
    RESET_in = 1'b0;
    run_op(1'b1, 1'b0, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 0, 1'b0);

    // Divide by zero.
    run_op(1'b1, 1'b0, 32'h1234_5678, 32'h09AB_CDEF, 1'b0, '0, '0, 0, 1'b0);
`ifdef MULT_DIV_DIVZERO_EN
    run_op(1'b0, 1'b1, 32'hDEAD_BEEF, 32'd0, 1'b0, '0, '0, 0, 1'b0);
    check("dz_keep_HI", {32'd0, HI}, {32'd0, mdl_hi});
    check("dz_keep_LO", {32'd0, LO}, {32'd0, mdl_lo});
`else
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 1'b0, '0, '0, 0, 1'b0);
`endif

    // Randomized operations with occasional start pulses while busy.
    for (int i = 0; i < 40; i++) begin
      int          kind;
      logic [31:0] ra;
      logic [31:0] rb;
      int          pl;
      kind = $urandom_range(0, 2);
      ra   = pick_operand();
      rb   = pick_operand();
      pl   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(2, 33);
      run_op(kind != 1, kind != 0, ra, rb, 1'b0, '0, '0, pl, 1'(($urandom_range(0, 1))));
    end

    repeat (3) @(negedge clock);
    check("scoreboard_empty", 64'(scb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
